// File: rtl/ofdm_pkg.sv
// Shared constants, beat field positions and FSM state types for the
// OFDM cyclic-prefix inserter.
package ofdm_pkg;
    localparam int DATA_W   = 38;
    localparam int REAL_MSB = 37;
    localparam int REAL_LSB = 22;
    localparam int IMAG_MSB = 21;
    localparam int IMAG_LSB = 6;
    localparam int EXP_MSB  = 5;

    typedef enum logic {
        WR_IDLE,
        WR_FILL
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_CP,
        RD_BODY
    } rd_state_t;
endpackage

// File: rtl/ofdm_cp_inserter_if.sv
// Avalon-ST sink (asi_in0) and source (aso_out0) bundle of the CP inserter.
interface ofdm_cp_inserter_if #(
    parameter int DATA_W = ofdm_pkg::DATA_W
);
    // A beat transfers on a rising edge where valid and ready are both high;
    // once valid is raised, data/sop/eop stay stable until that edge.
    logic [DATA_W-1:0] asi_in0_data;
    logic              asi_in0_valid;
    logic              asi_in0_ready;
    logic              asi_in0_startofpacket;
    logic              asi_in0_endofpacket;
    logic [DATA_W-1:0] aso_out0_data;
    logic              aso_out0_valid;
    logic              aso_out0_ready;
    logic              aso_out0_startofpacket;
    logic              aso_out0_endofpacket;

    modport master (
        output asi_in0_data, asi_in0_valid, asi_in0_startofpacket, asi_in0_endofpacket,
        input  asi_in0_ready,
        input  aso_out0_data, aso_out0_valid, aso_out0_startofpacket, aso_out0_endofpacket,
        output aso_out0_ready
    );

    modport slave (
        input  asi_in0_data, asi_in0_valid, asi_in0_startofpacket, asi_in0_endofpacket,
        output asi_in0_ready,
        output aso_out0_data, aso_out0_valid, aso_out0_startofpacket, aso_out0_endofpacket,
        input  aso_out0_ready
    );
endinterface

// File: rtl/ofdm_frame_ram.sv
// Two-bank symbol store: one synchronous write port, one asynchronous read
// port, both addressed by {bank, idx}. Contents are not reset.
module ofdm_frame_ram #(
    parameter  int DATA_W  = 38,
    parameter  int FFT_LEN = 64,
    localparam int IDX_W   = $clog2(FFT_LEN)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              wr_bank,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_bank,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [2*FFT_LEN];

    always_ff @(posedge clk) begin
        if (we) mem[{wr_bank, wr_idx}] <= wr_data;
    end

    assign rd_data = mem[{rd_bank, rd_idx}];
endmodule

// File: rtl/ofdm_cp_inserter.sv
// Buffers one IFFT symbol per input packet in a ping-pong store and re-emits
// it as {last CP_LEN samples, full symbol} in one output packet.
module ofdm_cp_inserter
    import ofdm_pkg::*;
#(
    parameter int FFT_LEN = 64,
    parameter int CP_LEN  = 16,
    parameter int DATA_W  = ofdm_pkg::DATA_W
) (
    input  logic                sample_clock_dac,
    input  logic                reset_reset_n,
    ofdm_cp_inserter_if.slave   st,
    output logic [7:0]          frames_dropped,
    output wr_state_t           dbg_wr_state,
    output rd_state_t           dbg_rd_state
);
    localparam int IDX_W = $clog2(FFT_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_LEN - 1);
    localparam logic [IDX_W-1:0] CP_START = IDX_W'(FFT_LEN - CP_LEN);

    wr_state_t         wr_state, wr_state_nxt;
    logic              wr_bank, wr_bank_nxt;
    logic [IDX_W-1:0]  wr_idx, wr_idx_nxt, ram_wr_idx;
    logic              in_accept, ram_we, wr_done, wr_drop;

    rd_state_t         rd_state, rd_state_nxt;
    logic              rd_bank, rd_bank_nxt;
    logic [IDX_W-1:0]  rd_idx, rd_idx_nxt;
    logic              rd_done, load, sop_nxt, eop_nxt, out_advance;
    logic [DATA_W-1:0] ram_rd_data;

    logic [1:0]        bank_full, bank_full_nxt;
    logic [DATA_W-1:0] out_data;
    logic              out_valid, out_sop, out_eop;

    assign st.asi_in0_ready        = ~bank_full[wr_bank];
    assign in_accept               = st.asi_in0_valid & st.asi_in0_ready;
    assign out_advance             = ~out_valid | st.aso_out0_ready;
    assign st.aso_out0_data        = out_data;
    assign st.aso_out0_valid       = out_valid;
    assign st.aso_out0_startofpacket = out_sop;
    assign st.aso_out0_endofpacket = out_eop;
    assign dbg_wr_state            = wr_state;
    assign dbg_rd_state            = rd_state;

    ofdm_frame_ram #(.DATA_W(DATA_W), .FFT_LEN(FFT_LEN)) u_ram (
        .clk     (sample_clock_dac),
        .we      (ram_we),
        .wr_bank (wr_bank),
        .wr_idx  (ram_wr_idx),
        .wr_data (st.asi_in0_data),
        .rd_bank (rd_bank_nxt),
        .rd_idx  (rd_idx_nxt),
        .rd_data (ram_rd_data)
    );

    // A sop always restarts at idx 0; arriving mid-fill it also drops the old frame.
    always_comb begin
        wr_state_nxt = wr_state;
        wr_bank_nxt  = wr_bank;
        wr_idx_nxt   = wr_idx;
        ram_we       = 1'b0;
        ram_wr_idx   = wr_idx;
        wr_done      = 1'b0;
        wr_drop      = 1'b0;
        if (in_accept) begin
            if (st.asi_in0_startofpacket) begin
                ram_we       = 1'b1;
                ram_wr_idx   = '0;
                wr_drop      = (wr_state == WR_FILL) | st.asi_in0_endofpacket;
                wr_state_nxt = st.asi_in0_endofpacket ? WR_IDLE : WR_FILL;
                wr_idx_nxt   = st.asi_in0_endofpacket ? '0 : IDX_W'(1);
            end else if (wr_state == WR_FILL) begin
                ram_we       = 1'b1;
                wr_state_nxt = WR_IDLE;
                wr_idx_nxt   = '0;
                if (st.asi_in0_endofpacket && wr_idx == LAST_IDX) begin
                    wr_done     = 1'b1;
                    wr_bank_nxt = ~wr_bank;
                end else if (st.asi_in0_endofpacket || wr_idx == LAST_IDX) begin
                    wr_drop = 1'b1;
                end else begin
                    wr_state_nxt = WR_FILL;
                    wr_idx_nxt   = wr_idx + 1'b1;
                end
            end
        end
    end

    // rd_bank/rd_idx name the sample held in the output register; the
    // next-state pair is also the RAM read address for the next load.
    always_comb begin
        rd_state_nxt = rd_state;
        rd_bank_nxt  = rd_bank;
        rd_idx_nxt   = rd_idx;
        rd_done      = 1'b0;
        load         = 1'b0;
        sop_nxt      = 1'b0;
        eop_nxt      = 1'b0;
        unique case (rd_state)
            RD_IDLE: begin
                if (bank_full[rd_bank]) begin
                    load         = 1'b1;
                    sop_nxt      = 1'b1;
                    rd_idx_nxt   = CP_START;
                    rd_state_nxt = RD_CP;
                end
            end
            RD_CP: begin
                if (out_advance) begin
                    load = 1'b1;
                    if (rd_idx == LAST_IDX) begin
                        rd_idx_nxt   = '0;
                        rd_state_nxt = RD_BODY;
                    end else begin
                        rd_idx_nxt = rd_idx + 1'b1;
                    end
                end
            end
            RD_BODY: begin
                if (out_advance) begin
                    if (rd_idx == LAST_IDX) begin
                        rd_done     = 1'b1;
                        rd_bank_nxt = ~rd_bank;
                        if (bank_full[~rd_bank]) begin
                            load         = 1'b1;
                            sop_nxt      = 1'b1;
                            rd_idx_nxt   = CP_START;
                            rd_state_nxt = RD_CP;
                        end else begin
                            rd_idx_nxt   = '0;
                            rd_state_nxt = RD_IDLE;
                        end
                    end else begin
                        load       = 1'b1;
                        rd_idx_nxt = rd_idx + 1'b1;
                        eop_nxt    = (rd_idx_nxt == LAST_IDX);
                    end
                end
            end
            default: rd_state_nxt = RD_IDLE;
        endcase
    end

    always_comb begin
        bank_full_nxt = bank_full;
        if (wr_done) bank_full_nxt[wr_bank] = 1'b1;
        if (rd_done) bank_full_nxt[rd_bank] = 1'b0;
    end

    always_ff @(posedge sample_clock_dac or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_state       <= WR_IDLE;
            wr_bank        <= 1'b0;
            wr_idx         <= '0;
            rd_state       <= RD_IDLE;
            rd_bank        <= 1'b0;
            rd_idx         <= '0;
            bank_full      <= 2'b00;
            frames_dropped <= 8'd0;
            out_data       <= '0;
            out_valid      <= 1'b0;
            out_sop        <= 1'b0;
            out_eop        <= 1'b0;
        end else begin
            wr_state  <= wr_state_nxt;
            wr_bank   <= wr_bank_nxt;
            wr_idx    <= wr_idx_nxt;
            rd_state  <= rd_state_nxt;
            rd_bank   <= rd_bank_nxt;
            rd_idx    <= rd_idx_nxt;
            bank_full <= bank_full_nxt;
            if (wr_drop && frames_dropped != 8'hFF) frames_dropped <= frames_dropped + 8'd1;
            if (load) begin
                out_data  <= ram_rd_data;
                out_valid <= 1'b1;
                out_sop   <= sop_nxt;
                out_eop   <= eop_nxt;
            end else if (rd_done) begin
                out_valid <= 1'b0;
                out_sop   <= 1'b0;
                out_eop   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ofdm_cp_inserter.sv
// Scoreboard bench for ofdm_cp_inserter: directed frames push expected
// output beats into exp_q, a negedge monitor pops and compares them.
module tb_ofdm_cp_inserter;
    import ofdm_pkg::*;

    localparam int FFT_LEN = 64;
    localparam int CP_LEN  = 16;
    localparam int PKT_LEN = FFT_LEN + CP_LEN;
    localparam int EXP_W   = DATA_W + 2;

    // ---------------- clock / reset ----------------
    logic      clk   = 1'b0;
    logic      rst_n = 1'b0;
    int        cyc   = 0;
    logic [7:0] frames_dropped;
    wr_state_t dbg_wr_state;
    rd_state_t dbg_rd_state;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ofdm_cp_inserter_if #(.DATA_W(DATA_W)) bus ();

    ofdm_cp_inserter #(.FFT_LEN(FFT_LEN), .CP_LEN(CP_LEN), .DATA_W(DATA_W)) dut (
        .sample_clock_dac (clk),
        .reset_reset_n    (rst_n),
        .st               (bus),
        .frames_dropped   (frames_dropped),
        .dbg_wr_state     (dbg_wr_state),
        .dbg_rd_state     (dbg_rd_state)
    );

    // ---------------- scoreboard state ----------------
    logic [EXP_W-1:0] exp_q[$];
    int               beat_cyc[$];
    int               beat_total = 0;
    int               tests      = 0;
    int               fails      = 0;
    int               sop_cyc    = 0;
    bit               bp_en      = 1'b0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [DATA_W-1:0] mk_data(input int tag, input int idx);
        logic [DATA_W-1:0] d;
        d = '0;
        d[REAL_MSB:REAL_LSB] = 16'(idx);
        d[IMAG_MSB:IMAG_LSB] = 16'(16'h5A00 + tag);
        d[EXP_MSB:0]         = 6'(tag);
        return d;
    endfunction

    // Expected packet: CP = samples 48..63, then body 0..63; sop on first, eop on last.
    task automatic push_frame(input int tag);
        int idx;
        for (int k = 0; k < PKT_LEN; k++) begin
            idx = (k < CP_LEN) ? (FFT_LEN - CP_LEN + k) : (k - CP_LEN);
            exp_q.push_back({mk_data(tag, idx), 1'(k == 0), 1'(k == PKT_LEN - 1)});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [DATA_W-1:0] d, input logic s, input logic e);
        int waited;
        waited = 0;
        bus.asi_in0_data          = d;
        bus.asi_in0_startofpacket = s;
        bus.asi_in0_endofpacket   = e;
        bus.asi_in0_valid         = 1'b1;
        while (bus.asi_in0_ready !== 1'b1 && waited < 2000) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (waited >= 2000) begin
            tests++;
            fails++;
            $display("FAIL in_ready_timeout: ready stuck at %0b, required 1", bus.asi_in0_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int tag, input int n_beats, input int eop_idx);
        for (int i = 0; i < n_beats; i++) begin
            send_beat(mk_data(tag, i), 1'(i == 0), 1'(i == eop_idx));
            if (i == 0) sop_cyc = cyc;
        end
        bus.asi_in0_valid         = 1'b0;
        bus.asi_in0_startofpacket = 1'b0;
        bus.asi_in0_endofpacket   = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- output ready (optional 30% backpressure) ----------------
    always @(posedge clk) begin
        #1;
        bus.aso_out0_ready = bp_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end

    // ---------------- monitor ----------------
    logic             prev_stall = 1'b0;
    logic [EXP_W:0]   prev_beat;
    logic [EXP_W-1:0] exp_beat;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", 64'({bus.aso_out0_valid, bus.aso_out0_data,
                      bus.aso_out0_startofpacket, bus.aso_out0_endofpacket}), 64'(prev_beat));
            if (bus.aso_out0_valid && bus.aso_out0_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got data %0h sop %0b eop %0b, required no beat",
                             bus.aso_out0_data, bus.aso_out0_startofpacket, bus.aso_out0_endofpacket);
                end else begin
                    exp_beat = exp_q.pop_front();
                    check("out_beat", 64'({bus.aso_out0_data, bus.aso_out0_startofpacket,
                          bus.aso_out0_endofpacket}), 64'(exp_beat));
                end
                beat_cyc.push_back(cyc);
                beat_total++;
            end
            prev_stall = bus.aso_out0_valid & ~bus.aso_out0_ready;
            prev_beat  = {1'b1, bus.aso_out0_data, bus.aso_out0_startofpacket, bus.aso_out0_endofpacket};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int mark;
        int n;
        bus.asi_in0_data          = '0;
        bus.asi_in0_valid         = 1'b0;
        bus.asi_in0_startofpacket = 1'b0;
        bus.asi_in0_endofpacket   = 1'b0;
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);

        check("rst_in_ready", 64'(bus.asi_in0_ready), 64'd1);
        check("rst_out_valid", 64'(bus.aso_out0_valid), 64'd0);
        check("rst_out_data", 64'(bus.aso_out0_data), 64'd0);
        check("rst_out_sop", 64'(bus.aso_out0_startofpacket), 64'd0);
        check("rst_out_eop", 64'(bus.aso_out0_endofpacket), 64'd0);
        check("rst_dropped", 64'(frames_dropped), 64'd0);
        check("rst_wr_state", 64'(dbg_wr_state), 64'(WR_IDLE));
        check("rst_rd_state", 64'(dbg_rd_state), 64'(RD_IDLE));

        // Single frame and first-beat latency.
        push_frame(1);
        send_frame(1, FFT_LEN, FFT_LEN - 1);
        check("lat_valid_at_E", 64'(bus.aso_out0_valid), 64'd0);
        idle(1);
        check("lat_valid_E1", 64'(bus.aso_out0_valid), 64'd1);
        check("lat_sop_E1", 64'(bus.aso_out0_startofpacket), 64'd1);
        check("lat_data_E1", 64'(bus.aso_out0_data), 64'(mk_data(1, FFT_LEN - CP_LEN)));
        wait_drain("drain_single", 300);

        // Three frames back-to-back, contiguous output.
        idle(2);
        beat_cyc.delete();
        push_frame(2);
        push_frame(3);
        push_frame(4);
        send_frame(2, FFT_LEN, FFT_LEN - 1);
        send_frame(3, FFT_LEN, FFT_LEN - 1);
        check("in_ready_both_full", 64'(bus.asi_in0_ready), 64'd0);
        send_frame(4, FFT_LEN, FFT_LEN - 1);
        wait_drain("drain_b2b", 500);
        check("b2b_beats", 64'(beat_cyc.size()), 64'(3 * PKT_LEN));
        if (beat_cyc.size() == 3 * PKT_LEN) begin
            check("b2b_contiguous", 64'(beat_cyc[3 * PKT_LEN - 1] - beat_cyc[0]), 64'(3 * PKT_LEN - 1));
            check("f3_after_f1_eop", 64'(sop_cyc > beat_cyc[PKT_LEN - 1] + 1), 64'd1);
        end

        // Random output backpressure.
        bp_en = 1'b1;
        push_frame(5);
        push_frame(6);
        send_frame(5, FFT_LEN, FFT_LEN - 1);
        send_frame(6, FFT_LEN, FFT_LEN - 1);
        wait_drain("drain_bp", 3000);
        bp_en = 1'b0;
        idle(3);

        // Malformed frames: stray beat, early eop, sop mid-fill, then a good frame.
        send_beat(mk_data(7, 5), 1'b0, 1'b0);
        bus.asi_in0_valid = 1'b0;
        send_frame(7, 41, 40);
        send_frame(8, 10, -1);
        push_frame(9);
        send_frame(9, FFT_LEN, FFT_LEN - 1);
        wait_drain("drain_malformed", 300);
        check("dropped_two", 64'(frames_dropped), 64'd2);

        // Reset in the middle of an output packet with a second frame buffering.
        idle(2);
        push_frame(10);
        mark = beat_total;
        fork
            begin
                send_frame(10, FFT_LEN, FFT_LEN - 1);
                send_frame(11, FFT_LEN, FFT_LEN - 1);
            end
            begin
                n = 0;
                while (beat_total < mark + 30 && n < 500) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                check("reset_beat30_reached", 64'(beat_total - mark), 64'd30);
                rst_n = 1'b0;
                #1;
                check("reset_async_valid", 64'(bus.aso_out0_valid), 64'd0);
                exp_q.delete();
                idle(2);
                rst_n = 1'b1;
            end
        join
        check("post_reset_ready", 64'(bus.asi_in0_ready), 64'd1);
        check("post_reset_dropped", 64'(frames_dropped), 64'd0);
        mark = beat_total;
        idle(200);
        check("no_stale_beats", 64'(beat_total - mark), 64'd0);
        push_frame(12);
        send_frame(12, FFT_LEN, FFT_LEN - 1);
        wait_drain("drain_post_reset", 300);

        // Short frames saturate the drop counter.
        for (int f = 0; f < 300; f++) begin
            send_frame(13, 2, 1);
            if (f == 99) check("dropped_100", 64'(frames_dropped), 64'd100);
        end
        idle(2);
        check("dropped_saturated", 64'(frames_dropped), 64'd255);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ofdm_cp_inserter.md
# ofdm_cp_inserter

Cyclic-prefix insertion stage directly upstream of the OFDM DAC control block. Accepts one IFFT output symbol per packet on an Avalon-ST sink, stores it in a ping-pong frame buffer, and re-emits the last CP_LEN samples followed by the full FFT_LEN-sample symbol as one Avalon-ST packet. Runs entirely in the DAC sample clock domain. The 38-bit beat format {real[37:22], imag[21:6], bfp_exp[5:0]} passes through bit-exact.

## Interface
- FFT_LEN, 64: samples per IFFT symbol; power of two, 8..1024.
- CP_LEN, 16: cyclic-prefix length; 1..FFT_LEN-1.
- DATA_W, 38: beat width.
- sample_clock_dac  in  1  sole clock; all logic is rising-edge.
- reset_reset_n  in  1  asynchronous, active-low reset.
- asi_in0_data  in  DATA_W  IFFT sample.
- asi_in0_valid  in  1  sink valid.
- asi_in0_ready  out  1  sink ready; 0 while the current write bank is full.
- asi_in0_startofpacket  in  1  first sample of a symbol.
- asi_in0_endofpacket  in  1  last sample of a symbol.
- aso_out0_data  out  DATA_W  output sample, registered.
- aso_out0_valid  out  1  source valid, registered.
- aso_out0_ready  in  1  source ready.
- aso_out0_startofpacket  out  1  first CP sample.
- aso_out0_endofpacket  out  1  last body sample.
- frames_dropped  out  8  saturating count of malformed input frames.

## Operation
- Storage: two banks of FFT_LEN x DATA_W. bank_full[1:0] flags. Contents are not reset.
- Write FSM, states WR_IDLE and WR_FILL; pointer wr_bank, index wr_idx.
  - WR_IDLE: beats accepted without sop are discarded (no count). Accepted sop beat writes idx 0, then go to WR_FILL.
  - WR_FILL: each accepted beat writes wr_idx. An eop beat at idx FFT_LEN-1 sets bank_full[wr_bank], toggles wr_bank and returns to WR_IDLE.
  - Malformed frame: eop at idx < FFT_LEN-1, or no eop at idx FFT_LEN-1. Increment frames_dropped (saturates at 255) and return to WR_IDLE; a new sop restarts at idx 0.
  - A sop arriving in WR_FILL also counts as malformed, and that beat starts a new frame at idx 0.
- asi_in0_ready = ~bank_full[wr_bank], combinational from registered state.
- Read FSM, states RD_IDLE, RD_CP, RD_BODY; pointer rd_bank, index rd_idx.
  - RD_IDLE: when bank_full[rd_bank] is set, load sample FFT_LEN-CP_LEN with sop=1, then go to RD_CP.
  - RD_CP: emits idx FFT_LEN-CP_LEN..FFT_LEN-1, then RD_BODY.
  - RD_BODY: emits idx 0..FFT_LEN-1; the last beat carries eop=1.
  - When the eop beat is accepted: clear bank_full[rd_bank] and toggle rd_bank. If the other bank is already full, load its first CP sample on the same edge (stay active, sop=1); otherwise go to RD_IDLE and deassert valid.
- Output register advances when ~aso_out0_valid | aso_out0_ready. Data, sop and eop are held stable while valid & ~ready.
- The same bank being both set and cleared on one edge cannot occur. A set on one bank and a clear on the other in the same cycle both take effect.

## Timing
- Reset values: aso_out0_valid=0, aso_out0_data=0, sop=0, eop=0, frames_dropped=0. Both FSMs idle, both banks empty, both pointers 0, so asi_in0_ready=1 in the first cycle after reset.
- Reset mid-operation discards any partial or buffered frames immediately (asynchronous). The output packet is truncated with no eop.
- Latency: the edge accepting input eop is E. bank_full is set at E. First CP beat is valid after edge E+1.
- Packet length is exactly CP_LEN+FFT_LEN beats. With ready held high, beats are contiguous.
- Back-to-back frames: no idle cycle between output packets when the next bank is full before the current eop is accepted.
- Input throughput: one beat per cycle while a bank is free. Two frames can be buffered.

## Structure
- Package ofdm_pkg holds: DATA_W, field slices (REAL_MSB=37, REAL_LSB=22, IMAG_MSB=21, IMAG_LSB=6, EXP_MSB=5), wr_state_t {WR_IDLE, WR_FILL}, rd_state_t {RD_IDLE, RD_CP, RD_BODY}.
- Sub-module ofdm_frame_ram: two-bank storage with one write port and one asynchronous read port, addressed by {bank, idx}. The top level keeps both FSMs, the flags and the output register.

## Test plan
Parameters FFT_LEN=64, CP_LEN=16.
- Single frame, data = idx: output sop beat is data 48, then 48..63, 0..63. 80 beats, eop on data 63, valid rises one cycle after the edge following input eop.
- Three frames pushed back-to-back with output ready=1: asi_in0_ready drops after frame 2. Output is 240 contiguous beats, and frame 3 is accepted once frame 1's eop leaves.
- Random 30% output backpressure: data/sop/eop are stable while valid & ~ready, and the sequence is identical to the unstalled run.
- Eop at idx 40, then a sop at idx 10 of the next frame, then a valid frame: frames_dropped=2, and only the valid frame is emitted.
- reset_reset_n pulsed low mid-output at beat 30: valid=0 asynchronously. After release, ready=1, no stale frame is emitted, and a new frame outputs correctly.
- 300 short frames: frames_dropped saturates at 255.
